angle_tracker: RTL and testbench

//  Successor to the single-rate beam angle mapper. Converts the debounced once-per-rev beam pulse into a

---
 rtl/angle_tracker.sv | 192 +++++++++++++++++++
 tb/tb_angle_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/angle_tracker.sv
// angle_tracker
//   Turns the debounced once-per-rev beam pulse into a drift-free angle.
//   A fractional phase accumulator advances by inc = 2^ACC_W / period_avg
//   every clock. The increment comes from a sequential restoring divider.
//   Glitch edges are rejected, lock and stall status are reported, a
//   constant angle offset is added, and the end of a revolution either
//   wraps or holds.
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   break_clean   debounced beam signal; a rising edge marks the index
//   theta_offset  angle added to the output (mod 2^THETA_BITS)
//   theta         registered current angle
//   rev_strobe    1-cycle pulse per accepted edge
//   locked        period estimate valid and stable
//   stalled       no edge for 2^PERIOD_BITS-1 clocks
//   period_avg    EMA of the revolution period in clocks (debug)
module angle_tracker #(
  parameter int THETA_BITS  = 8,
  parameter int FRAC_BITS   = 16,
  parameter int PERIOD_BITS = 28,
  parameter int EMA_SHIFT   = 3,
  parameter int MIN_PERIOD  = 1024,
  parameter int LOCK_COUNT  = 4,
  parameter int HOLD_AT_END = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   break_clean,
  input  logic [THETA_BITS-1:0]  theta_offset,
  output logic [THETA_BITS-1:0]  theta,
  output logic                   rev_strobe,
  output logic                   locked,
  output logic                   stalled,
  output logic [PERIOD_BITS-1:0] period_avg
);
  localparam int ACC_W = THETA_BITS + FRAC_BITS;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int LC_W  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int PB    = PERIOD_BITS;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, STALLED} state_t;

  state_t            state_q, state_d;
  logic              prev_beam_q, prev_beam_d;
  logic [PB-1:0]     cnt_q, cnt_d;
  logic [PB-1:0]     avg_q, avg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  inc_q, inc_d;
  logic [THETA_BITS-1:0] theta_q, theta_d;
  logic              strobe_q, strobe_d;
  logic              locked_q, locked_d;
  logic              stalled_q, stalled_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic              div_busy_q, div_busy_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [PB-1:0]     div_rem_q, div_rem_d;
  logic [ACC_W-1:0]  div_quo_q, div_quo_d;
  logic [PB-1:0]     div_den_q, div_den_d;

  logic              rise, tracking, accept, cnt_max;
  logic [PB-1:0]     elapsed, new_avg;
  logic [ACC_W:0]    acc_sum;
  logic              div_bit, div_ge, div_last;
  logic [PB:0]       div_trial;
  logic [ACC_W:0]    div_quo_nx;

  always_comb begin
    rise     = break_clean & ~prev_beam_q;
    cnt_max  = &cnt_q;
    // Clocks since the last accepted edge, counting the current cycle.
    elapsed  = cnt_max ? cnt_q : cnt_q + PB'(1);
    tracking = (state_q == ACQUIRE) || (state_q == LOCKED);
    accept   = rise && (!tracking || (elapsed >= PB'(MIN_PERIOD)));
    new_avg  = (avg_q == '0) ? elapsed
             : avg_q - (avg_q >> EMA_SHIFT) + (elapsed >> EMA_SHIFT);
    acc_sum  = {1'b0, acc_q} + {1'b0, inc_q};

    // Dividend is 2^ACC_W: a single 1 followed by ACC_W zeros.
    div_bit    = (div_cnt_q == CNT_W'(ACC_W));
    div_trial  = {div_rem_q, div_bit};
    div_ge     = (div_trial >= {1'b0, div_den_q});
    div_quo_nx = {div_quo_q, div_ge};
    div_last   = div_busy_q && (div_cnt_q == '0);

    state_d     = state_q;
    prev_beam_d = break_clean;
    cnt_d       = elapsed;
    avg_d       = avg_q;
    acc_d       = acc_q;
    inc_d       = inc_q;
    strobe_d    = 1'b0;
    stalled_d   = stalled_q;
    lock_cnt_d  = lock_cnt_q;
    div_busy_d  = div_busy_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_den_d   = div_den_q;

    if (div_busy_q) begin
      div_rem_d = div_ge ? PB'(div_trial - {1'b0, div_den_q}) : div_trial[PB-1:0];
      div_quo_d = div_quo_nx[ACC_W-1:0];
      div_cnt_d = div_cnt_q - CNT_W'(1);
      if (div_last) begin
        div_busy_d = 1'b0;
        // Only avg <= 1 produces a quotient bit at 2^ACC_W.
        inc_d = div_quo_nx[ACC_W] ? '1 : div_quo_nx[ACC_W-1:0];
      end
    end

    if (accept) begin
      cnt_d    = '0;
      acc_d    = '0;
      strobe_d = 1'b1;
      if (!tracking) begin
        // Period still unknown: start acquiring without a sample.
        state_d    = ACQUIRE;
        lock_cnt_d = '0;
        stalled_d  = 1'b0;
      end else begin
        avg_d      = new_avg;
        lock_cnt_d = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + LC_W'(1);
        div_busy_d = 1'b1;
        div_cnt_d  = CNT_W'(ACC_W);
        div_rem_d  = '0;
        div_quo_d  = '0;
        div_den_d  = new_avg;
      end
    end else if (tracking && cnt_max) begin
      state_d    = STALLED;
      stalled_d  = 1'b1;
      avg_d      = '0;
      inc_d      = '0;
      acc_d      = '0;
      div_busy_d = 1'b0;
    end else if (tracking) begin
      if (acc_sum[ACC_W] && (HOLD_AT_END != 0)) acc_d = '1;
      else                                     acc_d = acc_sum[ACC_W-1:0];
      if ((state_q == ACQUIRE) && div_last && (lock_cnt_q >= LC_W'(LOCK_COUNT)))
        state_d = LOCKED;
    end else begin
      acc_d = '0;
    end

    locked_d = (state_d == LOCKED);
    theta_d  = acc_q[ACC_W-1 -: THETA_BITS] + theta_offset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_beam_q <= 1'b0;
      cnt_q       <= '0;
      avg_q       <= '0;
      acc_q       <= '0;
      inc_q       <= '0;
      theta_q     <= '0;
      strobe_q    <= 1'b0;
      locked_q    <= 1'b0;
      stalled_q   <= 1'b0;
      lock_cnt_q  <= '0;
      div_busy_q  <= 1'b0;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_den_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_beam_q <= prev_beam_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      theta_q     <= theta_d;
      strobe_q    <= strobe_d;
      locked_q    <= locked_d;
      stalled_q   <= stalled_d;
      lock_cnt_q  <= lock_cnt_d;
      div_busy_q  <= div_busy_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_den_q   <= div_den_d;
    end
  end

  assign theta      = theta_q;
  assign rev_strobe = strobe_q;
  assign locked     = locked_q;
  assign stalled    = stalled_q;
  assign period_avg = avg_q;
endmodule

// File: tb/tb_angle_tracker.sv
// Bench for angle_tracker: two instances share one stimulus, one wrapping
// at the end of a revolution and one holding at the maximum angle.
module tb_angle_tracker;
  localparam int TB = 4;
  localparam int FB = 8;
  localparam int PB = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          break_clean = 1'b0;
  logic [TB-1:0] theta_offset = '0;
  logic [TB-1:0] theta_a, theta_b;
  logic          strobe_a, strobe_b, locked_a, locked_b, stalled_a, stalled_b;
  logic [PB-1:0] avg_a, avg_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  angle_tracker #(.THETA_BITS(TB), .FRAC_BITS(FB), .PERIOD_BITS(PB), .EMA_SHIFT(3),
                  .MIN_PERIOD(16), .LOCK_COUNT(2), .HOLD_AT_END(0)) u_wrap (
    .clk(clk), .reset(reset), .break_clean(break_clean), .theta_offset(theta_offset),
    .theta(theta_a), .rev_strobe(strobe_a), .locked(locked_a), .stalled(stalled_a),
    .period_avg(avg_a));

  angle_tracker #(.THETA_BITS(TB), .FRAC_BITS(FB), .PERIOD_BITS(PB), .EMA_SHIFT(3),
                  .MIN_PERIOD(16), .LOCK_COUNT(2), .HOLD_AT_END(1)) u_hold (
    .clk(clk), .reset(reset), .break_clean(break_clean), .theta_offset(theta_offset),
    .theta(theta_b), .rev_strobe(strobe_b), .locked(locked_b), .stalled(stalled_b),
    .period_avg(avg_b));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One revolution per record: edge at cycle 0, two checkpoints (cycles
  // after the edge cycle), expected values computed by hand.
  typedef struct {
    int period; int off;
    int c0; int th0; int thb0; int lk0;
    int c1; int th1; int thb1; int lk1; int avg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nstrobe;
    vecs[0] = '{256, 0,   1,  0,  0, 0, 200,  0,  0, 0,   0}; // IDLE->ACQUIRE, no sample
    vecs[1] = '{256, 0,  13,  0,  0, 0, 100,  5,  5, 0, 256}; // first sample, inc=16 after divide
    vecs[2] = '{256, 0,  13,  0,  0, 0,  14,  0,  0, 1, 256}; // lock 13 clks after 3rd edge
    vecs[3] = '{256, 0,  18,  1,  1, 1, 256, 15, 15, 1, 256}; // one step per 16 clks
    vecs[4] = '{256, 5,   2,  5,  5, 1, 256,  4,  4, 1, 256}; // offset 5, wraps to 4
    vecs[5] = '{512, 0, 258,  0, 15, 1, 300,  2, 15, 1, 256}; // long rev: wrap vs hold
    vecs[6] = '{256, 0,   1, 15, 15, 1, 100,  5,  5, 1, 288}; // EMA 256->288, inc 16->14
    vecs[7] = '{256, 0,   2,  0,  0, 1,  50,  2,  2, 1, 284}; // EMA 288->284

    // Reset values
    repeat (3) tick();
    chk("rst_theta", theta_a, 0);
    chk("rst_strobe", strobe_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_stalled", stalled_a, 0);
    chk("rst_avg", avg_a, 0);
    reset = 1'b0;
    tick();

    foreach (vecs[v]) begin
      theta_offset = TB'(vecs[v].off);
      break_clean = 1'b1;
      for (int j = 1; j <= vecs[v].period; j++) begin
        tick();
        if (j == 4) break_clean = 1'b0;
        if (j == 1) chk($sformatf("v%0d_strobe_hi", v), strobe_a, 1);
        if (j == 2) chk($sformatf("v%0d_strobe_lo", v), strobe_b, 0);
        if (j == vecs[v].c0) begin
          chk($sformatf("v%0d_theta_a@%0d", v, j), theta_a, vecs[v].th0);
          chk($sformatf("v%0d_theta_b@%0d", v, j), theta_b, vecs[v].thb0);
          chk($sformatf("v%0d_locked@%0d", v, j), locked_a, vecs[v].lk0);
        end
        if (j == vecs[v].c1) begin
          chk($sformatf("v%0d_theta_a@%0d", v, j), theta_a, vecs[v].th1);
          chk($sformatf("v%0d_theta_b@%0d", v, j), theta_b, vecs[v].thb1);
          chk($sformatf("v%0d_locked_a@%0d", v, j), locked_a, vecs[v].lk1);
          chk($sformatf("v%0d_locked_b@%0d", v, j), locked_b, vecs[v].lk1);
          chk($sformatf("v%0d_avg_a", v), avg_a, vecs[v].avg);
          chk($sformatf("v%0d_avg_b", v), avg_b, vecs[v].avg);
        end
      end
    end

    // Glitch rise 8 clks after the edge, then no more edges until stall.
    theta_offset = '0;
    nstrobe = 0;
    break_clean = 1'b1;
    for (int j = 1; j <= 4098; j++) begin
      tick();
      if (j == 4) break_clean = 1'b0;
      if (j == 7) break_clean = 1'b1;
      if (j == 9) break_clean = 1'b0;
      if (j <= 256 && strobe_a) nstrobe++;
      if (j == 9) begin
        chk("glitch_strobe", strobe_a, 0);
        chk("glitch_avg", avg_a, 281);
      end
      if (j == 100) begin
        chk("glitch_theta_a", theta_a, 5);
        chk("glitch_theta_b", theta_b, 5);
        chk("glitch_locked", locked_a, 1);
        chk("glitch_avg_late", avg_a, 281);
      end
      if (j == 256) chk("glitch_nstrobe", nstrobe, 1);
      if (j == 4096) begin
        chk("prestall_stalled", stalled_a, 0);
        chk("prestall_locked", locked_a, 1);
      end
      if (j == 4097) begin
        chk("stall_stalled_a", stalled_a, 1);
        chk("stall_stalled_b", stalled_b, 1);
        chk("stall_locked", locked_a, 0);
        chk("stall_avg", avg_a, 0);
      end
      if (j == 4098) chk("stall_theta", theta_a, 0);
    end

    // Recovery from STALLED: rise goes to ACQUIRE with no sample.
    break_clean = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      tick();
      if (j == 4) break_clean = 1'b0;
      if (j == 1) begin
        chk("recover_strobe", strobe_a, 1);
        chk("recover_stalled", stalled_a, 0);
        chk("recover_locked", locked_a, 0);
        chk("recover_avg", avg_a, 0);
      end
    end

    // Next edge samples and starts a division; reset in the middle of it.
    break_clean = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 4) break_clean = 1'b0;
      if (j == 2) chk("predrst_avg", avg_a, 256);
    end
    reset = 1'b1;
    tick();
    chk("midrst_theta", theta_a, 0);
    chk("midrst_strobe", strobe_a, 0);
    chk("midrst_locked", locked_a, 0);
    chk("midrst_stalled", stalled_a, 0);
    chk("midrst_avg", avg_a, 0);
    reset = 1'b0;
    theta_offset = TB'(3);
    tick();
    tick();
    chk("idle_offset_theta", theta_a, 3);

    // After reset the first edge is from IDLE and inc is zero again.
    break_clean = 1'b1;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (j == 4) break_clean = 1'b0;
      if (j == 1) begin
        chk("postrst_strobe", strobe_a, 1);
        chk("postrst_avg", avg_a, 0);
      end
      if (j == 100) begin
        chk("postrst_theta", theta_a, 3);
        chk("postrst_locked", locked_a, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
